// File: rtl/axil_resp_mem.sv
// axil_resp_mem: AXI4-Lite subordinate backed by a 2**DEPTH_LOG2-word memory with independent read/write paths.
// Optional: define AXIL_RESP_MEM_SLVERR_EN to answer out-of-range accesses with SLVERR instead of aliasing.
module axil_resp_mem #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DEPTH_LOG2 = 6,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int unsigned           RD_LATENCY = 1
) (
   input  logic                    s00_axi_aclk,
   input  logic                    s00_axi_aresetn,
   input  logic [ADDR_WIDTH-1:0]   s00_axi_awaddr,
   input  logic [2:0]              s00_axi_awprot,
   input  logic                    s00_axi_awvalid,
   output logic                    s00_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s00_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s00_axi_wstrb,
   input  logic                    s00_axi_wvalid,
   output logic                    s00_axi_wready,
   output logic [1:0]              s00_axi_bresp,
   output logic                    s00_axi_bvalid,
   input  logic                    s00_axi_bready,
   input  logic [ADDR_WIDTH-1:0]   s00_axi_araddr,
   input  logic [2:0]              s00_axi_arprot,
   input  logic                    s00_axi_arvalid,
   output logic                    s00_axi_arready,
   output logic [DATA_WIDTH-1:0]   s00_axi_rdata,
   output logic [1:0]              s00_axi_rresp,
   output logic                    s00_axi_rvalid,
   input  logic                    s00_axi_rready,
   output logic [15:0]             wr_count,
   output logic [15:0]             rd_count
);
   localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned DIFF_W = ADDR_WIDTH + 1;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
`ifdef AXIL_RESP_MEM_SLVERR_EN
   localparam bit SLVERR_EN = 1'b1;
`else
   localparam bit SLVERR_EN = 1'b0;
`endif

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

   w_state_t w_state, w_state_d;
   r_state_t r_state, r_state_d;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  aw_held, aw_held_d, w_held, w_held_d;
   logic [ADDR_WIDTH-1:0] aw_addr, ar_addr, ar_addr_d;
   logic [DATA_WIDTH-1:0] w_data, rdata_d;
   logic [STRB_W-1:0]     w_strb;
   logic                  awready_d, wready_d, bvalid_d, arready_d, rvalid_d;
   logic [1:0]            bresp_d, rresp_d;
   logic [15:0]           wr_count_d, rd_count_d;
   logic [CNT_W-1:0]      rd_cnt, rd_cnt_d;
   logic                  mem_we, aw_take, w_take, ar_take;

   // Address decode: borrow bit of the base subtraction flags addresses below BASE_ADDR
   logic [DIFF_W-1:0]     aw_diff, ar_diff;
   logic [DEPTH_LOG2-1:0] aw_idx, ar_idx;
   logic                  aw_ok, ar_ok;

   assign aw_diff = {1'b0, aw_addr} - {1'b0, BASE_ADDR};
   assign ar_diff = {1'b0, ar_addr} - {1'b0, BASE_ADDR};
   assign aw_idx  = aw_diff[DEPTH_LOG2+1:2];
   assign ar_idx  = ar_diff[DEPTH_LOG2+1:2];
   assign aw_ok   = !SLVERR_EN || (!aw_diff[ADDR_WIDTH] && (aw_diff[ADDR_WIDTH-1:DEPTH_LOG2+2] == '0));
   assign ar_ok   = !SLVERR_EN || (!ar_diff[ADDR_WIDTH] && (ar_diff[ADDR_WIDTH-1:DEPTH_LOG2+2] == '0));

   assign aw_take = s00_axi_awvalid && s00_axi_awready;
   assign w_take  = s00_axi_wvalid && s00_axi_wready;
   assign ar_take = s00_axi_arvalid && s00_axi_arready;

   logic unused_bits;
   assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, aw_diff[1:0], ar_diff[1:0]};

   // Write path: collect AW and W in any order, commit one edge after both are held
   always_comb begin
      w_state_d  = w_state;
      aw_held_d  = aw_held;
      w_held_d   = w_held;
      awready_d  = s00_axi_awready;
      wready_d   = s00_axi_wready;
      bvalid_d   = s00_axi_bvalid;
      bresp_d    = s00_axi_bresp;
      wr_count_d = wr_count;
      mem_we     = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (aw_held && w_held) begin
               mem_we    = aw_ok;
               bvalid_d  = 1'b1;
               bresp_d   = aw_ok ? RESP_OKAY : RESP_SLVERR;
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               awready_d = 1'b0;
               wready_d  = 1'b0;
               w_state_d = W_RESP;
            end else begin
               aw_held_d = aw_held || aw_take;
               w_held_d  = w_held || w_take;
               awready_d = !(aw_held || aw_take);
               wready_d  = !(w_held || w_take);
            end
         end
         W_RESP: begin
            awready_d = 1'b0;
            wready_d  = 1'b0;
            if (s00_axi_bvalid && s00_axi_bready) begin
               bvalid_d   = 1'b0;
               bresp_d    = RESP_OKAY;
               awready_d  = 1'b1;
               wready_d   = 1'b1;
               wr_count_d = wr_count + 16'd1;
               w_state_d  = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Read path: the AR edge captures the address; data is sampled RD_LATENCY edges later
   always_comb begin
      r_state_d  = r_state;
      ar_addr_d  = ar_addr;
      rd_cnt_d   = rd_cnt;
      arready_d  = s00_axi_arready;
      rvalid_d   = s00_axi_rvalid;
      rdata_d    = s00_axi_rdata;
      rresp_d    = s00_axi_rresp;
      rd_count_d = rd_count;
      case (r_state)
         R_IDLE: begin
            if (ar_take) begin
               ar_addr_d = s00_axi_araddr;
               rd_cnt_d  = CNT_W'(RD_LATENCY);
               arready_d = 1'b0;
               r_state_d = R_WAIT;
            end else begin
               arready_d = 1'b1;
            end
         end
         R_WAIT: begin
            if (rd_cnt == CNT_W'(1)) begin
               rvalid_d  = 1'b1;
               rdata_d   = ar_ok ? mem[ar_idx] : '0;
               rresp_d   = ar_ok ? RESP_OKAY : RESP_SLVERR;
               r_state_d = R_DATA;
            end else begin
               rd_cnt_d = rd_cnt - CNT_W'(1);
            end
         end
         R_DATA: begin
            if (s00_axi_rvalid && s00_axi_rready) begin
               rvalid_d   = 1'b0;
               arready_d  = 1'b1;
               rd_count_d = rd_count + 16'd1;
               r_state_d  = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         w_state         <= W_IDLE;
         r_state         <= R_IDLE;
         aw_held         <= 1'b0;
         w_held          <= 1'b0;
         aw_addr         <= '0;
         w_data          <= '0;
         w_strb          <= '0;
         ar_addr         <= '0;
         rd_cnt          <= '0;
         s00_axi_awready <= 1'b0;
         s00_axi_wready  <= 1'b0;
         s00_axi_bvalid  <= 1'b0;
         s00_axi_bresp   <= RESP_OKAY;
         s00_axi_arready <= 1'b0;
         s00_axi_rvalid  <= 1'b0;
         s00_axi_rdata   <= '0;
         s00_axi_rresp   <= RESP_OKAY;
         wr_count        <= '0;
         rd_count        <= '0;
      end else begin
         w_state         <= w_state_d;
         r_state         <= r_state_d;
         aw_held         <= aw_held_d;
         w_held          <= w_held_d;
         ar_addr         <= ar_addr_d;
         rd_cnt          <= rd_cnt_d;
         s00_axi_awready <= awready_d;
         s00_axi_wready  <= wready_d;
         s00_axi_bvalid  <= bvalid_d;
         s00_axi_bresp   <= bresp_d;
         s00_axi_arready <= arready_d;
         s00_axi_rvalid  <= rvalid_d;
         s00_axi_rdata   <= rdata_d;
         s00_axi_rresp   <= rresp_d;
         wr_count        <= wr_count_d;
         rd_count        <= rd_count_d;
         if (aw_take) aw_addr <= s00_axi_awaddr;
         if (w_take) begin
            w_data <= s00_axi_wdata;
            w_strb <= s00_axi_wstrb;
         end
      end
   end

   // Storage: byte-enabled write at the commit edge
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (mem_we) begin
         for (int b = 0; b < int'(STRB_W); b++) begin
            if (w_strb[b]) mem[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_axil_resp_mem.sv
// tb_axil_resp_mem: self-checking bench for axil_resp_mem with a word-array reference model.
// Expectations follow AXIL_RESP_MEM_SLVERR_EN when it is defined for the build.
module tb_axil_resp_mem;
   localparam int unsigned RD_LAT = 3;
   localparam int unsigned DEPTH  = 64;
   localparam logic [31:0] BASE   = 32'h0000_0000;
`ifdef AXIL_RESP_MEM_SLVERR_EN
   localparam bit SLV = 1'b1;
`else
   localparam bit SLV = 1'b0;
`endif

   logic        clk, rst_n;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;
   logic [15:0] wr_count, rd_count;

   axil_resp_mem #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(6), .BASE_ADDR(BASE), .RD_LATENCY(RD_LAT)
   ) dut (
      .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
      .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
      .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
      .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
      .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
      .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
      .wr_count(wr_count), .rd_count(rd_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fails  = 0;
   logic [31:0] model [DEPTH];
   logic [15:0] exp_wr, exp_rd;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   // Reference model: plain word array, modular index arithmetic
   function automatic bit m_ok(input logic [31:0] a);
      logic [32:0] diff;
      diff = {1'b0, a} - {1'b0, BASE};
      return !SLV || (!diff[32] && diff[31:0] < 32'(4 * DEPTH));
   endfunction

   function automatic int m_idx(input logic [31:0] a);
      return int'(((a - BASE) / 32'd4) % 32'(DEPTH));
   endfunction

   function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      if (!m_ok(a)) return;
      for (int b = 0; b < 4; b++)
         if (s[b]) model[m_idx(a)][8*b +: 8] = d[8*b +: 8];
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
      exp_wr = '0;
      exp_rd = '0;
   endfunction

   // Caller is at a negedge with bready high
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output int lat);
      int t;
      resp = 2'b11;
      lat  = -1;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      t = 0;
      while (!(awready && wready) && t < 20) begin @(negedge clk); t++; end
      if (t == 20) begin
         check("aw_w_ready_timeout", 32'(t), 32'd0);
         awvalid = 1'b0; wvalid = 1'b0;
         return;
      end
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      lat = 0;
      while (!bvalid && lat < 40) begin @(negedge clk); lat++; end
      resp = bresp;
      if (!bvalid) begin
         check("bvalid_timeout", 32'(bvalid), 32'd1);
         return;
      end
      @(negedge clk);
      model_write(a, d, s);
      exp_wr++;
      check("wr_count", 32'(wr_count), 32'(exp_wr));
      check("bvalid_clear", 32'(bvalid), 32'd0);
   endtask

   // Caller is at a negedge with rready high
   task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                           output int lat);
      int t;
      d = '1; resp = 2'b11; lat = -1;
      araddr = a; arvalid = 1'b1;
      t = 0;
      while (!arready && t < 20) begin @(negedge clk); t++; end
      if (t == 20) begin
         check("arready_timeout", 32'(t), 32'd0);
         arvalid = 1'b0;
         return;
      end
      @(negedge clk);
      arvalid = 1'b0;
      lat = 0;
      while (!rvalid && lat < 40) begin @(negedge clk); lat++; end
      d = rdata;
      resp = rresp;
      if (!rvalid) begin
         check("rvalid_timeout", 32'(rvalid), 32'd1);
         return;
      end
      @(negedge clk);
      exp_rd++;
      check("rd_count", 32'(rd_count), 32'(exp_rd));
      check("rvalid_clear", 32'(rvalid), 32'd0);
   endtask

   task automatic wr_chk(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [1:0] r, er;
      int l;
      er = m_ok(a) ? 2'b00 : 2'b10;
      axi_write(a, d, s, r, l);
      check({tag, "_bresp"}, 32'(r), 32'(er));
      check({tag, "_blat"}, 32'(l), 32'd1);
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a);
      logic [31:0] ed, rd;
      logic [1:0]  er, r;
      int l;
      ed = m_ok(a) ? model[m_idx(a)] : 32'h0;
      er = m_ok(a) ? 2'b00 : 2'b10;
      axi_read(a, rd, r, l);
      check({tag, "_rdata"}, rd, ed);
      check({tag, "_rresp"}, 32'(r), 32'(er));
      check({tag, "_rlat"}, 32'(l), 32'(RD_LAT));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      int          l;

      tbl[0] = '{1'b1, 32'h10, 32'hA5A5_5A5A, 4'hF,    32'h0};
      tbl[1] = '{1'b0, 32'h10, 32'h0,         4'h0,    32'hA5A5_5A5A};
      tbl[2] = '{1'b1, 32'h12, 32'h1234_5678, 4'b0101, 32'h0};
      tbl[3] = '{1'b0, 32'h13, 32'h0,         4'h0,    32'hA534_5A78};
      tbl[4] = '{1'b1, 32'hFC, 32'hCAFE_F00D, 4'b1000, 32'h0};
      tbl[5] = '{1'b0, 32'hFC, 32'h0,         4'h0,    32'hCA00_0000};
      tbl[6] = '{1'b1, 32'h14, 32'hFFFF_FFFF, 4'b0000, 32'h0};
      tbl[7] = '{1'b0, 32'h14, 32'h0,         4'h0,    32'h0};
      tbl[8] = '{1'b0, 32'h00, 32'h0,         4'h0,    32'h0};

      awaddr = '0; wdata = '0; wstrb = '0; araddr = '0; awprot = '0; arprot = '0;
      awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
      model_clear();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;

      // Reset: everything low, readies rise one edge after release
      repeat (5) @(negedge clk);
      check("rst_readies", 32'({awready, wready, arready}), 32'd0);
      check("rst_valids", 32'({bvalid, rvalid}), 32'd0);
      check("rst_resp_data", 32'({bresp, rresp}) | rdata, 32'd0);
      check("rst_counts", {wr_count, rd_count}, 32'd0);
      rst_n = 1'b1;
      #1 check("rel_readies_before_edge", 32'({awready, wready, arready}), 32'd0);
      @(negedge clk);
      check("rel_readies", 32'({awready, wready, arready}), 32'b111);
      rd_chk("rst_read", 32'h3C);

      // Simultaneous AW/W then a latency-3 read
      axi_write(32'h04, 32'hDEAD_BEEF, 4'hF, r, l);
      check("t2_blat", 32'(l), 32'd1);
      check("t2_bresp", 32'(r), 32'd0);
      check("t2_wr_count", 32'(wr_count), 32'd1);
      axi_read(32'h04, d, r, l);
      check("t2_rlat", 32'(l), 32'd3);
      check("t2_rdata", d, 32'hDEAD_BEEF);

      // Vector table
      for (int i = 0; i < 9; i++) begin
         if (tbl[i].wr) begin
            axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, r, l);
            check($sformatf("tbl%0d_bresp", i), 32'(r), 32'd0);
            check($sformatf("tbl%0d_blat", i), 32'(l), 32'd1);
         end else begin
            axi_read(tbl[i].addr, d, r, l);
            check($sformatf("tbl%0d_rdata", i), d, tbl[i].exp);
            check($sformatf("tbl%0d_rresp", i), 32'(r), 32'd0);
         end
      end

      // W three cycles ahead of AW, single byte lane
      wr_chk("t3_pre", 32'h08, 32'h1122_3344, 4'hF);
      wdata = 32'h0000_AB00; wstrb = 4'b0010; wvalid = 1'b1;
      check("t3_wready", 32'(wready), 32'd1);
      @(negedge clk);
      wvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("t3_wait", 32'({bvalid, awready, wready}), 32'b010);
         @(negedge clk);
      end
      awaddr = 32'h08; awvalid = 1'b1;
      check("t3_awready", 32'(awready), 32'd1);
      @(negedge clk);
      awvalid = 1'b0;
      check("t3_bvalid_lat0", 32'(bvalid), 32'd0);
      @(negedge clk);
      check("t3_bvalid_lat1", 32'({bvalid, bresp}), 32'b100);
      @(negedge clk);
      model_write(32'h08, 32'h0000_AB00, 4'b0010);
      exp_wr++;
      check("t3_wr_count", 32'(wr_count), 32'(exp_wr));
      axi_read(32'h08, d, r, l);
      check("t3_merged", d, 32'h1122_AB44);

      // B back-pressure for 10 cycles with a new AW/W waiting
      bready = 1'b0;
      awaddr = 32'h30; wdata = 32'h0F0F_0F0F; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      check("t4_ready", 32'({awready, wready}), 32'b11);
      @(negedge clk);
      awaddr = 32'h34; wdata = 32'h7777_7777;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         check("t4_stall", 32'({bvalid, bresp, awready, wready}), 32'b10000);
         @(negedge clk);
      end
      check("t4_count_hold", 32'(wr_count), 32'(exp_wr));
      awvalid = 1'b0; wvalid = 1'b0;
      bready = 1'b1;
      @(negedge clk);
      model_write(32'h30, 32'h0F0F_0F0F, 4'hF);
      exp_wr++;
      check("t4_wr_count", 32'(wr_count), 32'(exp_wr));
      check("t4_reopen", 32'({bvalid, awready, wready}), 32'b011);
      rd_chk("t4_rd30", 32'h30);
      rd_chk("t4_rd34", 32'h34);

      // Out-of-range access: SLVERR with the option, aliasing to word 0 without
      wr_chk("t5_pre", 32'h00, 32'h0BAD_F00D, 4'hF);
      axi_write(BASE + 32'h100, 32'h5555_AAAA, 4'hF, r, l);
      check("t5_bresp", 32'(r), SLV ? 32'd2 : 32'd0);
      axi_read(BASE + 32'h100, d, r, l);
      check("t5_rresp", 32'(r), SLV ? 32'd2 : 32'd0);
      check("t5_rdata", d, SLV ? 32'h0 : 32'h5555_AAAA);
      axi_read(BASE, d, r, l);
      check("t5_word0", d, SLV ? 32'h0BAD_F00D : 32'h5555_AAAA);

      // Same-word write committed on the R_DATA entry edge, then reset while RVALID is high
      wr_chk("t6_pre", 32'h20, 32'h1111_1111, 4'hF);
      rready = 1'b0;
      araddr = 32'h20; arvalid = 1'b1;
      check("t6_arready", 32'(arready), 32'd1);
      @(negedge clk);
      arvalid = 1'b0;
      @(negedge clk);
      awaddr = 32'h20; wdata = 32'h2222_2222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      check("t6_aw_w_ready", 32'({awready, wready}), 32'b11);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      check("t6_rvalid_early", 32'(rvalid), 32'd0);
      @(negedge clk);
      check("t6_rvalid", 32'(rvalid), 32'd1);
      check("t6_bvalid", 32'(bvalid), 32'd1);
      check("t6_rdata_old", rdata, 32'h1111_1111);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rvalid_drop", 32'(rvalid), 32'd0);
      check("t6_bvalid_drop", 32'(bvalid), 32'd0);
      check("t6_rd_count", 32'(rd_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      rready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t6_no_r", 32'({rvalid, rd_count}), 32'd0);
      end
      rd_chk("t6_after", 32'h20);

      // Randomized traffic against the model
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a;
         a = 32'($urandom_range(0, 32'h1FF));
         if ($urandom_range(0, 1) == 1)
            wr_chk("rnd_wr", a, $urandom, 4'($urandom_range(0, 15)));
         else
            rd_chk("rnd_rd", a);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
